// File: rtl/pc_gen_pkg.sv
// Shared defines for the fetch PC generator: enable levels and FSM encoding.
package pc_gen_pkg;

  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;
  localparam logic ENABLE       = 1'b1;
  localparam logic DISABLE      = 1'b0;
  localparam logic NO_STOP      = 1'b0;

  // OFF: memory disabled, RUN: normal fetch, PEND: jump captured under stall
  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } pc_state_e;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC / delay-slot selection for pc_gen.
module pc_next_sel
  import pc_gen_pkg::*;
#(
  parameter int              ADDR_W    = 16,
  parameter int              PC_STEP   = 1,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
  input  pc_state_e          state,
  input  logic [ADDR_W-1:0]  pc,
  input  logic [ADDR_W-1:0]  pend_tgt,
  input  logic               stall0,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  flush_pc,
  input  logic               jump,
  input  logic [ADDR_W-1:0]  jump_tgt,
  input  logic               ids,
  output logic [ADDR_W-1:0]  pc_nxt,
  output logic               ids_nxt
);

  // step truncated to the address width; the add wraps with no carry out
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  // priority: flush > new jump > pending jump > stall hold > increment
  always_comb begin
    pc_nxt  = pc;
    ids_nxt = ids;
    if (state == ST_OFF) begin
      // leaving OFF presents RESET_VEC once before any update
      pc_nxt  = RESET_VEC;
      ids_nxt = DISABLE;
    end else if (flush) begin
      pc_nxt  = flush_pc;
      ids_nxt = DISABLE;
    end else if (jump) begin
      ids_nxt = ENABLE;
      if (!stall0) pc_nxt = jump_tgt;
    end else if (state == ST_PEND && !stall0) begin
      pc_nxt = pend_tgt;
    end else if (!stall0) begin
      pc_nxt  = pc + STEP;
      ids_nxt = DISABLE;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Instruction fetch PC generator with flush, jump and stall-deferred jump.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int                ADDR_W    = 16,
  parameter int                PC_STEP   = 1,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int                STALL_W   = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  flush_pc,
  input  logic               jump_i,
  input  logic [ADDR_W-1:0]  jump_target_addr_i,
  output logic [ADDR_W-1:0]  pc,
  output logic               ce,
  output logic               in_delay_slot_o,
  output logic               jump_pending_o
);

  pc_state_e         state, state_nxt;
  logic [ADDR_W-1:0] tgt_q, tgt_nxt, pc_nxt;
  logic              ids_q, ids_nxt;
  logic              stall0;

  // only the fetch-stage stall bit matters here
  assign stall0 = (stall[0] != NO_STOP);
  logic unused_stall;
  assign unused_stall = ^stall[STALL_W-1:1];

  pc_next_sel #(
    .ADDR_W   (ADDR_W),
    .PC_STEP  (PC_STEP),
    .RESET_VEC(RESET_VEC)
  ) u_sel (
    .state   (state),
    .pc      (pc),
    .pend_tgt(tgt_q),
    .stall0  (stall0),
    .flush   (flush),
    .flush_pc(flush_pc),
    .jump    (jump_i),
    .jump_tgt(jump_target_addr_i),
    .ids     (ids_q),
    .pc_nxt  (pc_nxt),
    .ids_nxt (ids_nxt)
  );

  // FSM next state and jump-target capture (latest jump under stall wins)
  always_comb begin
    state_nxt = state;
    tgt_nxt   = tgt_q;
    unique case (state)
      ST_OFF: state_nxt = ST_RUN;
      ST_RUN, ST_PEND: begin
        if (flush) begin
          state_nxt = ST_RUN;
        end else if (jump_i) begin
          if (stall0) begin
            tgt_nxt   = jump_target_addr_i;
            state_nxt = ST_PEND;
          end else begin
            state_nxt = ST_RUN;
          end
        end else if (state == ST_PEND && !stall0) begin
          state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_OFF;
    endcase
  end

  // state, pc, delay-slot and captured target registers; sync reset wins over all
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_OFF;
      pc    <= RESET_VEC;
      ids_q <= DISABLE;
      tgt_q <= RESET_VEC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      ids_q <= ids_nxt;
      tgt_q <= tgt_nxt;
    end
  end

  assign ce              = (state == ST_OFF) ? CHIP_DISABLE : CHIP_ENABLE;
  assign in_delay_slot_o = ids_q;
  assign jump_pending_o  = (state == ST_PEND);

endmodule

// File: tb/tb_pc_gen.sv
// Randomized bench for pc_gen against a behavioural fetch-address model.
module tb_pc_gen;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [15:0] flush_pc;
  logic        jump_i;
  logic [15:0] jt;

  logic [15:0] pc;
  logic        ce, ids, jp;
  logic [3:0]  s_pc;
  logic        s_ce, s_ids, s_jp;

  int checks = 0;
  int errors = 0;

  pc_gen dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .flush_pc(flush_pc),
    .jump_i(jump_i), .jump_target_addr_i(jt),
    .pc(pc), .ce(ce), .in_delay_slot_o(ids), .jump_pending_o(jp)
  );

  pc_gen #(.ADDR_W(4), .PC_STEP(2), .RESET_VEC(4'hA), .STALL_W(6)) dut_s (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .flush_pc(flush_pc[3:0]),
    .jump_i(jump_i), .jump_target_addr_i(jt[3:0]),
    .pc(s_pc), .ce(s_ce), .in_delay_slot_o(s_ids), .jump_pending_o(s_jp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // fetch model: running flag, pending flag, held target, current address
  typedef struct packed {
    bit          on;
    bit          pend;
    bit          ids;
    bit          known;
    logic [31:0] pc;
    logic [31:0] tgt;
  } mdl_t;

  mdl_t mm = '0;
  mdl_t ms = '0;

  function automatic mdl_t mstep(mdl_t m, int unsigned mask, int unsigned step,
                                 int unsigned rv);
    mdl_t n = m;
    if (rst) begin
      n.on = 0; n.pend = 0; n.ids = 0; n.known = 1; n.pc = rv;
    end else if (!m.on) begin
      n.on = 1; n.pc = rv; n.ids = 0; n.known = 1;
    end else if (flush) begin
      n.pc = flush_pc & mask; n.pend = 0; n.ids = 0; n.known = 1;
    end else if (jump_i) begin
      n.ids = 1; n.known = 1;
      if (stall[0]) begin n.pend = 1; n.tgt = jt & mask; end
      else begin n.pend = 0; n.pc = jt & mask; end
    end else if (m.pend && !stall[0]) begin
      n.pc = m.tgt; n.pend = 0; n.known = 0;
    end else if (!stall[0]) begin
      n.pc = (m.pc + step) & mask; n.ids = 0; n.known = 1;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    mm = mstep(mm, 32'hFFFF, 1, 0);
    ms = mstep(ms, 32'hF, 2, 32'hA);
    @(posedge clk);
    #1;
    chk("pc", {16'h0, pc}, mm.pc);
    chk("ce", {31'h0, ce}, {31'h0, mm.on});
    chk("pend", {31'h0, jp}, {31'h0, mm.pend});
    if (mm.known) chk("ids", {31'h0, ids}, {31'h0, mm.ids});
    chk("s_pc", {28'h0, s_pc}, ms.pc);
    chk("s_ce", {31'h0, s_ce}, {31'h0, ms.on});
    chk("s_pend", {31'h0, s_jp}, {31'h0, ms.pend});
    if (ms.known) chk("s_ids", {31'h0, s_ids}, {31'h0, ms.ids});
  endtask

  initial begin
    rst = 1; stall = '0; flush = 0; flush_pc = '0; jump_i = 0; jt = '0;
    // reset release sequence
    repeat (3) begin
      tick();
      chk("rst_ce", {31'h0, ce}, 0);
      chk("rst_pc", {16'h0, pc}, 0);
    end
    rst = 0;
    tick();
    chk("rel_ce", {31'h0, ce}, 1);
    chk("rel_pc", {16'h0, pc}, 0);
    chk("s_rel_pc", {28'h0, s_pc}, 32'hA);
    tick(); chk("seq1", {16'h0, pc}, 1);
    tick(); chk("seq2", {16'h0, pc}, 2);
    tick(); chk("seq3", {16'h0, pc}, 3);
    chk("s_wrap", {28'h0, s_pc}, 0);
    tick(); tick();
    chk("pc5", {16'h0, pc}, 5);
    // unstalled jump
    jump_i = 1; jt = 16'h0040;
    tick();
    jump_i = 0;
    chk("jmp_pc", {16'h0, pc}, 32'h40);
    chk("jmp_ids", {31'h0, ids}, 1);
    tick();
    chk("jmp_seq", {16'h0, pc}, 32'h41);
    chk("jmp_ids_clr", {31'h0, ids}, 0);
    // jump under stall
    flush = 1; flush_pc = 16'h0008;
    tick();
    flush = 0;
    stall = 6'b000001; jump_i = 1; jt = 16'h0100;
    tick();
    jump_i = 0;
    chk("pend_hold", {16'h0, pc}, 8);
    chk("pend_set", {31'h0, jp}, 1);
    tick(); tick();
    chk("pend_hold3", {16'h0, pc}, 8);
    stall = '0;
    tick();
    chk("pend_apply", {16'h0, pc}, 32'h100);
    chk("pend_clr", {31'h0, jp}, 0);
    // flush beats jump while pending
    stall = 6'b000001; jump_i = 1; jt = 16'h0300;
    tick();
    flush = 1; flush_pc = 16'h0004; jt = 16'h0200;
    tick();
    flush = 0; jump_i = 0;
    chk("flush_pc", {16'h0, pc}, 4);
    chk("flush_pend", {31'h0, jp}, 0);
    chk("flush_ids", {31'h0, ids}, 0);
    // reset mid-PEND discards captured target
    jump_i = 1; jt = 16'h0500;
    tick();
    jump_i = 0; rst = 1;
    tick();
    chk("rpend_pc", {16'h0, pc}, 0);
    chk("rpend_ce", {31'h0, ce}, 0);
    chk("rpend_jp", {31'h0, jp}, 0);
    rst = 0; stall = '0;
    tick();
    chk("rpend_rel", {16'h0, pc}, 0);
    tick();
    chk("rpend_noapply", {16'h0, pc}, 1);
    // random traffic, upper stall bits toggled freely
    for (int i = 0; i < 800; i++) begin
      rst      = ($urandom_range(39) == 0);
      flush    = ($urandom_range(11) == 0);
      jump_i   = ($urandom_range(5) == 0);
      flush_pc = 16'($urandom);
      jt       = 16'($urandom);
      stall    = 6'($urandom);
      stall[0] = ($urandom_range(2) == 0);
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
